// File: rtl/ks_ctrl_bank.sv
// rtl/ks_ctrl_bank.sv - per-channel string parameter bank; optional glide on volume/tuning via KS_CTRL_GLIDE_EN
module ks_ctrl_bank #(
    parameter int NUM_CH     = 4,
    parameter int PW         = 10,
    parameter int GLIDE_STEP = 8,
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 lrck,
    input  logic                 rst_n,
    input  logic                 msg_en,
    input  logic                 msg_bcast,
    input  logic [CHW-1:0]       msg_ch,
    input  logic [8:0]           msg_addr,
    input  logic [3*PW+1:0]      msg,
    output logic [NUM_CH*PW-1:0] delay_o,
    output logic [NUM_CH*PW-1:0] stretch_o,
    output logic [NUM_CH*PW-1:0] loss_o,
    output logic [NUM_CH*PW-1:0] tuning_o,
    output logic [NUM_CH*PW-1:0] dynamics_o,
    output logic [NUM_CH*PW-1:0] volume_o,
    output logic [NUM_CH*PW-1:0] sympat_o,
    output logic [NUM_CH-1:0]    pluck_o,
    output logic [NUM_CH-1:0]    panic_o,
    output logic [NUM_CH-1:0]    busy_o,
    output logic                 msg_err
);
    localparam int NP       = 7;
    localparam int P_TUNING = 3;
    localparam int P_VOLUME = 5;

    function automatic logic [PW-1:0] rst_val(input int p);
        case (p)
            0:       rst_val = PW'(48);
            1:       rst_val = PW'(1) << (PW - 1);
            2:       rst_val = {{(PW-1){1'b1}}, 1'b0};
            5:       rst_val = '1;
            default: rst_val = '0;
        endcase
    endfunction

    // One glide step toward tgt; sgn selects two's-complement interpretation.
    function automatic logic [PW-1:0] glide(input logic [PW-1:0] cur, input logic [PW-1:0] tgt,
                                            input logic sgn);
        logic signed [PW+1:0] c, t, d, st;
        c  = {{2{sgn & cur[PW-1]}}, cur};
        t  = {{2{sgn & tgt[PW-1]}}, tgt};
        d  = t - c;
        st = (PW+2)'(GLIDE_STEP);
        if (d > st)       glide = PW'(c + st);
        else if (d < -st) glide = PW'(c - st);
        else              glide = tgt;
    endfunction

    logic [NP-1:0]     wr_en;
    logic [PW-1:0]     wr_val [NP];
    logic [NUM_CH-1:0] hit;
    logic              err;
    logic [PW-1:0]     par_q  [NUM_CH][NP];
    logic [PW-1:0]     par_nx [NUM_CH][NP];
    logic [NUM_CH-1:0] pluck_q, panic_q;
    logic              err_q;
`ifdef KS_CTRL_GLIDE_EN
    logic [PW-1:0]     tgt_q  [NUM_CH][2];
    logic [PW-1:0]     tgt_nx [NUM_CH][2];
    logic [NUM_CH-1:0] busy_q, busy_nx;
`endif

    // Later slots overwrite earlier ones, so slot3 wins on a collision.
    always_comb begin
        wr_en = '0;
        for (int p = 0; p < NP; p++) wr_val[p] = '0;
        for (int s = 0; s < 3; s++)
            for (int p = 0; p < NP; p++)
                if (msg_addr[8-3*s -: 3] == 3'(p + 1)) begin
                    wr_en[p]  = 1'b1;
                    wr_val[p] = msg[3*PW+1-s*PW -: PW];
                end
    end

    always_comb begin
        err = msg_en && !msg_bcast && ({1'b0, msg_ch} >= (CHW+1)'(NUM_CH));
        for (int k = 0; k < NUM_CH; k++)
            hit[k] = msg_en && (msg_bcast || msg_ch == CHW'(k));
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            for (int p = 0; p < NP; p++)
                par_nx[k][p] = (hit[k] && wr_en[p]) ? wr_val[p] : par_q[k][p];
`ifdef KS_CTRL_GLIDE_EN
        // Busy reflects whether the output still had ground to cover at this edge.
        for (int k = 0; k < NUM_CH; k++) begin
            tgt_nx[k][0] = (hit[k] && wr_en[P_TUNING]) ? wr_val[P_TUNING] : tgt_q[k][0];
            tgt_nx[k][1] = (hit[k] && wr_en[P_VOLUME]) ? wr_val[P_VOLUME] : tgt_q[k][1];
            par_nx[k][P_TUNING] = glide(par_q[k][P_TUNING], tgt_nx[k][0], 1'b1);
            par_nx[k][P_VOLUME] = glide(par_q[k][P_VOLUME], tgt_nx[k][1], 1'b0);
            busy_nx[k] = (par_q[k][P_TUNING] != tgt_nx[k][0]) ||
                         (par_q[k][P_VOLUME] != tgt_nx[k][1]);
        end
`endif
    end

    always_ff @(posedge lrck) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                for (int p = 0; p < NP; p++)
                    par_q[k][p] <= rst_val(p);
            pluck_q <= '0;
            panic_q <= '0;
            err_q   <= 1'b0;
`ifdef KS_CTRL_GLIDE_EN
            for (int k = 0; k < NUM_CH; k++) begin
                tgt_q[k][0] <= rst_val(P_TUNING);
                tgt_q[k][1] <= rst_val(P_VOLUME);
            end
            busy_q <= '0;
`endif
        end else begin
            par_q   <= par_nx;
            pluck_q <= hit & {NUM_CH{msg[0]}};
            panic_q <= hit & {NUM_CH{msg[1]}};
            err_q   <= err;
`ifdef KS_CTRL_GLIDE_EN
            tgt_q  <= tgt_nx;
            busy_q <= busy_nx;
`endif
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign delay_o[k*PW +: PW]    = par_q[k][0];
        assign stretch_o[k*PW +: PW]  = par_q[k][1];
        assign loss_o[k*PW +: PW]     = par_q[k][2];
        assign tuning_o[k*PW +: PW]   = par_q[k][3];
        assign dynamics_o[k*PW +: PW] = par_q[k][4];
        assign volume_o[k*PW +: PW]   = par_q[k][5];
        assign sympat_o[k*PW +: PW]   = par_q[k][6];
    end

    assign pluck_o = pluck_q;
    assign panic_o = panic_q;
    assign msg_err = err_q;
`ifdef KS_CTRL_GLIDE_EN
    assign busy_o = busy_q;
`else
    assign busy_o = '0;
`endif
endmodule

// File: tb/tb_ks_ctrl_bank.sv
// tb/tb_ks_ctrl_bank.sv - self-checking bench for ks_ctrl_bank (glide checks with KS_CTRL_GLIDE_EN)
module tb_ks_ctrl_bank;
    localparam int NCH  = 5;
    localparam int PW   = 10;
    localparam int STEP = 8;
`ifdef KS_CTRL_GLIDE_EN
    localparam bit GLIDE = 1'b1;
`else
    localparam bit GLIDE = 1'b0;
`endif

    logic              lrck = 1'b0;
    logic              rst_n = 1'b0;
    logic              msg_en = 1'b0;
    logic              msg_bcast = 1'b0;
    logic [2:0]        msg_ch = '0;
    logic [8:0]        msg_addr = '0;
    logic [3*PW+1:0]   msg = '0;
    logic [NCH*PW-1:0] delay_o, stretch_o, loss_o, tuning_o, dynamics_o, volume_o, sympat_o;
    logic [NCH-1:0]    pluck_o, panic_o, busy_o;
    logic              msg_err;

    int n_cmp = 0;
    int n_err = 0;
    int m_par [NCH][7];
    int m_tgt [NCH][7];
    logic [NCH-1:0] m_pluck, m_panic, m_busy;
    logic           m_err;

    ks_ctrl_bank #(.NUM_CH(NCH), .PW(PW), .GLIDE_STEP(STEP)) dut (
        .lrck(lrck), .rst_n(rst_n), .msg_en(msg_en), .msg_bcast(msg_bcast), .msg_ch(msg_ch),
        .msg_addr(msg_addr), .msg(msg), .delay_o(delay_o), .stretch_o(stretch_o), .loss_o(loss_o),
        .tuning_o(tuning_o), .dynamics_o(dynamics_o), .volume_o(volume_o), .sympat_o(sympat_o),
        .pluck_o(pluck_o), .panic_o(panic_o), .busy_o(busy_o), .msg_err(msg_err)
    );

    always #5 lrck = ~lrck;

    function automatic int rst_value(input int p);
        case (p)
            0: return 48;
            1: return 512;
            2: return 1022;
            5: return 1023;
            default: return 0;
        endcase
    endfunction

    function automatic logic [PW-1:0] dut_par(input int k, input int p);
        case (p)
            0: return delay_o[k*PW +: PW];
            1: return stretch_o[k*PW +: PW];
            2: return loss_o[k*PW +: PW];
            3: return tuning_o[k*PW +: PW];
            4: return dynamics_o[k*PW +: PW];
            5: return volume_o[k*PW +: PW];
            default: return sympat_o[k*PW +: PW];
        endcase
    endfunction

    function automatic bit is_glide(input int p);
        return GLIDE && (p == 3 || p == 5);
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit bc, input int ch,
                              input logic [8:0] addr, input logic [31:0] v);
        int code, val, d;
        bit hit;
        if (rst) begin
            for (int k = 0; k < NCH; k++)
                for (int p = 0; p < 7; p++) begin
                    m_par[k][p] = rst_value(p);
                    m_tgt[k][p] = rst_value(p);
                end
            m_pluck = '0; m_panic = '0; m_busy = '0; m_err = 1'b0;
            return;
        end
        m_err = en && !bc && ch >= NCH;
        for (int k = 0; k < NCH; k++) begin
            hit = en && (bc || ch == k);
            m_pluck[k] = hit & v[0];
            m_panic[k] = hit & v[1];
            if (hit)
                for (int s = 0; s < 3; s++) begin
                    code = int'((addr >> (6 - 3*s)) & 9'd7);
                    val  = int'((v >> (22 - 10*s)) & 32'd1023);
                    if (code == 4 && val >= 512) val -= 1024;
                    if (code != 0) begin
                        if (is_glide(code - 1)) m_tgt[k][code-1] = val;
                        else                    m_par[k][code-1] = val;
                    end
                end
            m_busy[k] = 1'b0;
            for (int p = 3; p <= 5; p += 2)
                if (is_glide(p)) begin
                    if (m_par[k][p] != m_tgt[k][p]) m_busy[k] = 1'b1;
                    d = m_tgt[k][p] - m_par[k][p];
                    if (d > STEP)       m_par[k][p] += STEP;
                    else if (d < -STEP) m_par[k][p] -= STEP;
                    else                m_par[k][p] = m_tgt[k][p];
                end
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit bc, input int ch,
                        input logic [8:0] addr, input logic [31:0] v);
        rst_n = ~rst; msg_en = en; msg_bcast = bc; msg_ch = 3'(ch); msg_addr = addr; msg = v;
        model_edge(rst, en, bc, ch, addr, v);
        @(posedge lrck);
        #1;
        rst_n = 1'b1; msg_en = 1'b0; msg_bcast = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 9'd0, 32'd0);
        for (int k = 0; k < NCH; k++)
            for (int p = 0; p < 7; p++) begin
                n_cmp++;
                if (dut_par(k, p) !== PW'(rst_value(p))) begin
                    n_err++;
                    $display("FAIL reset ch%0d p%0d got %0d want %0d", k, p, dut_par(k, p), rst_value(p));
                end
            end
        n_cmp++;
        if ({pluck_o, panic_o, busy_o, msg_err} !== '0) begin
            n_err++;
            $display("FAIL reset_pulses got %b want 0", {pluck_o, panic_o, busy_o, msg_err});
        end
    endtask

    task automatic test_slots();
        step(0, 1, 0, 2, {3'd1, 3'd1, 3'd3}, {10'd100, 10'd200, 10'd300, 2'b00});
        n_cmp++;
        if (delay_o[2*PW +: PW] !== 10'd200) begin
            n_err++; $display("FAIL slot_win delay ch2 got %0d want 200", delay_o[2*PW +: PW]);
        end
        n_cmp++;
        if (loss_o[2*PW +: PW] !== 10'd300) begin
            n_err++; $display("FAIL slot3 loss ch2 got %0d want 300", loss_o[2*PW +: PW]);
        end
        n_cmp++;
        if (delay_o[1*PW +: PW] !== 10'd48 || loss_o[3*PW +: PW] !== 10'd1022) begin
            n_err++; $display("FAIL slot_other got %0d/%0d want 48/1022", delay_o[1*PW +: PW], loss_o[3*PW +: PW]);
        end
        n_cmp++;
        if (pluck_o !== 5'b0) begin
            n_err++; $display("FAIL slot_pluck got %b want 0", pluck_o);
        end
    endtask

    task automatic test_bcast_err();
        step(0, 1, 1, 6, {3'd2, 3'd0, 3'd0}, {10'd77, 20'd0, 2'b01});
        n_cmp++;
        if (pluck_o !== 5'b11111 || msg_err !== 1'b0) begin
            n_err++; $display("FAIL bcast_pluck got %b err %b want 11111 err 0", pluck_o, msg_err);
        end
        n_cmp++;
        if (stretch_o[0 +: PW] !== 10'd77 || stretch_o[4*PW +: PW] !== 10'd77) begin
            n_err++; $display("FAIL bcast_stretch got %0d/%0d want 77", stretch_o[0 +: PW], stretch_o[4*PW +: PW]);
        end
        step(0, 0, 0, 0, 9'd0, 32'd0);
        n_cmp++;
        if (pluck_o !== 5'b0) begin
            n_err++; $display("FAIL pluck_one_cycle got %b want 0", pluck_o);
        end
        step(0, 1, 0, 5, {3'd1, 3'd7, 3'd2}, {10'd5, 10'd6, 10'd7, 2'b11});
        n_cmp++;
        if (msg_err !== 1'b1 || pluck_o !== 5'b0 || panic_o !== 5'b0) begin
            n_err++; $display("FAIL err_pulse got err %b pluck %b panic %b want 1/0/0", msg_err, pluck_o, panic_o);
        end
        n_cmp++;
        if (delay_o[0 +: PW] !== 10'd48 || sympat_o[4*PW +: PW] !== 10'd0 || stretch_o[0 +: PW] !== 10'd77) begin
            n_err++; $display("FAIL err_nochange got %0d/%0d/%0d want 48/0/77",
                              delay_o[0 +: PW], sympat_o[4*PW +: PW], stretch_o[0 +: PW]);
        end
        step(0, 0, 0, 0, 9'd0, 32'd0);
        n_cmp++;
        if (msg_err !== 1'b0) begin
            n_err++; $display("FAIL err_one_cycle got %b want 0", msg_err);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 1, {3'd6, 3'd4, 3'd1}, {10'd0, 10'd100, 10'd9, 2'b01});
        step(0, 0, 0, 0, 9'd0, 32'd0);
        step(1, 1, 1, 0, {3'd1, 3'd0, 3'd0}, {10'd300, 22'h3});
        n_cmp++;
        if (delay_o[0 +: PW] !== 10'd48 || delay_o[1*PW +: PW] !== 10'd48 || stretch_o[0 +: PW] !== 10'd512) begin
            n_err++; $display("FAIL rstmid_param got %0d/%0d/%0d want 48/48/512",
                              delay_o[0 +: PW], delay_o[1*PW +: PW], stretch_o[0 +: PW]);
        end
        n_cmp++;
        if (volume_o[1*PW +: PW] !== 10'd1023 || tuning_o[1*PW +: PW] !== 10'd0) begin
            n_err++; $display("FAIL rstmid_glide got %0d/%0d want 1023/0", volume_o[1*PW +: PW], tuning_o[1*PW +: PW]);
        end
        n_cmp++;
        if ({busy_o, pluck_o, panic_o} !== '0) begin
            n_err++; $display("FAIL rstmid_flags got %b want 0", {busy_o, pluck_o, panic_o});
        end
    endtask

`ifdef KS_CTRL_GLIDE_EN
    task automatic test_glide();
        logic [PW-1:0] vol_seq [4];
        logic [PW-1:0] tun_seq [5];
        logic [3:0]    bsy_seq;
        vol_seq[0] = 10'd1015; vol_seq[1] = 10'd1007; vol_seq[2] = 10'd1000; vol_seq[3] = 10'd1000;
        bsy_seq = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(0, 1, 0, 0, {3'd6, 6'd0}, {10'd1000, 22'd0});
            else        step(0, 0, 0, 0, 9'd0, 32'd0);
            n_cmp++;
            if (volume_o[0 +: PW] !== vol_seq[i] || busy_o[0] !== bsy_seq[i]) begin
                n_err++; $display("FAIL glide_vol[%0d] got %0d busy %b want %0d busy %b",
                                  i, volume_o[0 +: PW], busy_o[0], vol_seq[i], bsy_seq[i]);
            end
        end
        tun_seq[0] = 10'h3F8; tun_seq[1] = 10'h3F0; tun_seq[2] = 10'h3F8; tun_seq[3] = 10'h000; tun_seq[4] = 10'h004;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      step(0, 1, 0, 0, {3'd4, 6'd0}, {10'h3EC, 22'd0});
            else if (i == 2) step(0, 1, 0, 0, {3'd4, 6'd0}, {10'd4, 22'd0});
            else             step(0, 0, 0, 0, 9'd0, 32'd0);
            n_cmp++;
            if (tuning_o[0 +: PW] !== tun_seq[i] || busy_o[0] !== 1'b1) begin
                n_err++; $display("FAIL glide_tun[%0d] got %h busy %b want %h busy 1",
                                  i, tuning_o[0 +: PW], busy_o[0], tun_seq[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit rst, en, bc;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            bc  = ($urandom_range(0, 7) == 0);
            step(rst, en, bc, int'($urandom_range(0, 7)), 9'($urandom), $urandom);
            for (int k = 0; k < NCH; k++)
                for (int p = 0; p < 7; p++) begin
                    n_cmp++;
                    if (dut_par(k, p) !== PW'(m_par[k][p])) begin
                        n_err++;
                        $display("FAIL rand[%0d] ch%0d p%0d got %0d want %0d", i, k, p, dut_par(k, p), PW'(m_par[k][p]));
                    end
                end
            n_cmp++;
            if ({pluck_o, panic_o, busy_o, msg_err} !== {m_pluck, m_panic, m_busy, m_err}) begin
                n_err++;
                $display("FAIL rand[%0d] flags got %b want %b", i,
                         {pluck_o, panic_o, busy_o, msg_err}, {m_pluck, m_panic, m_busy, m_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_slots();
        test_bcast_err();
        test_reset_mid();
`ifdef KS_CTRL_GLIDE_EN
        test_glide();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
